// File: rtl/pu_or1k_store_buffer.sv
// Store buffer: a FIFO of pending stores {pc, adr, dat, bsel, atomic}.
// Pointers carry one extra wrap bit, so full and empty can be told apart.
// Pops are delivered one cycle later through registered output fields.
module pu_or1k_store_buffer #(
  parameter int unsigned DEPTH_WIDTH          = 4,
  parameter int unsigned OPTION_OPERAND_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,

  input  logic [OPTION_OPERAND_WIDTH-1:0]   pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_i,
  input  logic                              atomic_i,
  input  logic                              write_i,
  input  logic                              read_i,
  input  logic                              flush_i,

  output logic [OPTION_OPERAND_WIDTH-1:0]   pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_o,
  output logic                              atomic_o,
  output logic                              valid_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [DEPTH_WIDTH:0]              count_o,
  output logic                              overflow_o
);

  localparam int unsigned Depth  = 2 ** DEPTH_WIDTH;
  localparam int unsigned OpW    = OPTION_OPERAND_WIDTH;
  localparam int unsigned BselW  = OPTION_OPERAND_WIDTH / 8;
  localparam int unsigned EntryW = 3 * OpW + BselW + 1;

  typedef logic [DEPTH_WIDTH:0] ptr_t;

  // Storage: no reset needed, pointers decide which words are live.
  logic [EntryW-1:0] mem [Depth];

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;

  logic [OpW-1:0]   pc_q, adr_q, dat_q;
  logic [BselW-1:0] bsel_q;
  logic             atomic_q;
  logic             valid_q;
  logic             overflow_q, overflow_d;

  logic             full, empty;
  logic             push_ok, pop_ok;
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] rd_entry;
  logic [DEPTH_WIDTH-1:0] widx, ridx;

  assign widx = wptr_q[DEPTH_WIDTH-1:0];
  assign ridx = rptr_q[DEPTH_WIDTH-1:0];

  // Status flags, purely from registered pointers.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (widx == ridx) && (wptr_q[DEPTH_WIDTH] != rptr_q[DEPTH_WIDTH]);
  end

  // Accept decisions use pre-edge flags; flush overrides both requests.
  always_comb begin
    push_ok = write_i && !full  && !flush_i;
    pop_ok  = read_i  && !empty && !flush_i;
  end

  // Next-state for pointers and the sticky overflow flag.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + ptr_t'(1);
      if (pop_ok)  rptr_d = rptr_q + ptr_t'(1);
      // A push that is refused because the buffer is full is a lost store.
      if (write_i && full) overflow_d = 1'b1;
    end
  end

  assign wr_entry = {pc_i, adr_i, dat_i, bsel_i, atomic_i};
  assign rd_entry = mem[ridx];

  // Array write port.
  always_ff @(posedge clk) begin
    if (push_ok) mem[widx] <= wr_entry;
  end

  // Pointer and flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      valid_q    <= pop_ok;
    end
  end

  // Registered read port; fields hold the last popped entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      bsel_q   <= '0;
      atomic_q <= 1'b0;
    end else if (pop_ok) begin
      {pc_q, adr_q, dat_q, bsel_q, atomic_q} <= rd_entry;
    end
  end

  assign pc_o       = pc_q;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign bsel_o     = bsel_q;
  assign atomic_o   = atomic_q;
  assign valid_o    = valid_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = wptr_q - rptr_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pu_or1k_store_buffer.sv
// Directed bench for pu_or1k_store_buffer; expected values are hand-derived.
module tb_pu_or1k_store_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_i, adr_i, dat_i;
  logic [3:0]  bsel_i;
  logic        atomic_i, write_i, read_i, flush_i;
  logic [31:0] pc_o, adr_o, dat_o;
  logic [3:0]  bsel_o;
  logic        atomic_o, valid_o, full_o, empty_o, overflow_o;
  logic [4:0]  count_o;

  int errors = 0;
  int checks = 0;

  pu_or1k_store_buffer #(
    .DEPTH_WIDTH          (4),
    .OPTION_OPERAND_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_i       (pc_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .bsel_i     (bsel_i),
    .atomic_i   (atomic_i),
    .write_i    (write_i),
    .read_i     (read_i),
    .flush_i    (flush_i),
    .pc_o       (pc_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .bsel_o     (bsel_o),
    .atomic_o   (atomic_o),
    .valid_o    (valid_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs (applied 1ns after an edge).
  task automatic set_in(input logic w, input logic r, input logic f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] p, input logic [3:0] b,
                        input logic at);
    write_i  = w;
    read_i   = r;
    flush_i  = f;
    adr_i    = a;
    dat_i    = d;
    pc_i     = p;
    bsel_i   = b;
    atomic_i = at;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #13;
    checks++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || count_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d, want 1 0 0",
               empty_o, full_o, count_o);
    end
    checks++;
    if (valid_o !== 1'b0 || overflow_o !== 1'b0 || adr_o !== 32'h0 || dat_o !== 32'h0
        || pc_o !== 32'h0 || bsel_o !== 4'h0 || atomic_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ovf=%b adr=%h dat=%h, want all zero",
               valid_o, overflow_o, adr_o, dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_in(1'b1, 1'b0, 1'b0, 32'h100, 32'hA5A5A5A5, 32'h2000, 4'hF, 1'b1);
    tick();
    checks++;
    if (count_o !== 5'd1 || empty_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_push: count=%0d empty=%b valid=%b, want 1 0 0",
               count_o, empty_o, valid_o);
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    checks++;
    if (valid_o !== 1'b1 || adr_o !== 32'h100 || dat_o !== 32'hA5A5A5A5
        || bsel_o !== 4'hF || pc_o !== 32'h2000 || atomic_o !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: valid=%b adr=%h dat=%h bsel=%h pc=%h at=%b, want 1 100 a5a5a5a5 f 2000 1",
               valid_o, adr_o, dat_o, bsel_o, pc_o, atomic_o);
    end
    checks++;
    if (empty_o !== 1'b1 || count_o !== 5'd0) begin
      errors++;
      $display("FAIL single_empty: empty=%b count=%0d, want 1 0", empty_o, count_o);
    end
    idle();
    tick();
    checks++;
    if (valid_o !== 1'b0 || adr_o !== 32'h100 || dat_o !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL single_hold: valid=%b adr=%h dat=%h, want 0 100 a5a5a5a5",
               valid_o, adr_o, dat_o);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 32'(i * 4), 32'hD000_0000 + 32'(i), 32'h1000 + 32'(i),
             4'(i), i[0]);
      tick();
    end
    checks++;
    if (full_o !== 1'b1 || count_o !== 5'd16 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d ovf=%b, want 1 16 0",
               full_o, count_o, overflow_o);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h1FFF, 4'h5, 1'b0);
    tick();
    checks++;
    if (full_o !== 1'b1 || count_o !== 5'd16 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow: full=%b count=%0d ovf=%b, want 1 16 1",
               full_o, count_o, overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    set_in(1'b1, 1'b1, 1'b0, 32'h44, 32'hBAD0_BAD0, 32'h1EEE, 4'h3, 1'b0);
    tick();
    checks++;
    if (valid_o !== 1'b1 || adr_o !== 32'h0 || dat_o !== 32'hD000_0000 || pc_o !== 32'h1000) begin
      errors++;
      $display("FAIL full_rw_pop: valid=%b adr=%h dat=%h pc=%h, want 1 0 d0000000 1000",
               valid_o, adr_o, dat_o, pc_o);
    end
    checks++;
    if (count_o !== 5'd15 || full_o !== 1'b0 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL full_rw_count: count=%0d full=%b ovf=%b, want 15 0 1",
               count_o, full_o, overflow_o);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i < 16; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
      tick();
      checks++;
      if (valid_o !== 1'b1 || adr_o !== 32'(i * 4) || dat_o !== 32'hD000_0000 + 32'(i)
          || bsel_o !== 4'(i) || atomic_o !== i[0]) begin
        errors++;
        $display("FAIL drain[%0d]: valid=%b adr=%h dat=%h bsel=%h at=%b, want 1 %h %h %h %b",
                 i, valid_o, adr_o, dat_o, bsel_o, atomic_o, i * 4,
                 32'hD000_0000 + 32'(i), 4'(i), i[0]);
      end
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    checks++;
    if (valid_o !== 1'b0 || empty_o !== 1'b1 || count_o !== 5'd0 || adr_o !== 32'h3C) begin
      errors++;
      $display("FAIL drain_empty: valid=%b empty=%b count=%0d adr=%h, want 0 1 0 3c",
               valid_o, empty_o, count_o, adr_o);
    end
  endtask

  task automatic test_empty_push_pop();
    set_in(1'b1, 1'b1, 1'b0, 32'h200, 32'h1234_5678, 32'h3000, 4'hC, 1'b0);
    tick();
    checks++;
    if (valid_o !== 1'b0 || count_o !== 5'd1 || adr_o !== 32'h3C) begin
      errors++;
      $display("FAIL empty_rw: valid=%b count=%0d adr=%h, want 0 1 3c", valid_o, count_o, adr_o);
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    checks++;
    if (valid_o !== 1'b1 || adr_o !== 32'h200 || dat_o !== 32'h1234_5678 || count_o !== 5'd0) begin
      errors++;
      $display("FAIL empty_rw_pop: valid=%b adr=%h dat=%h count=%0d, want 1 200 12345678 0",
               valid_o, adr_o, dat_o, count_o);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    for (int k = 0; k < 40; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(k * 4), 32'(k), 32'h0, 4'h1, 1'b0);
      tick();
      set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
      tick();
      checks++;
      if (valid_o !== 1'b1 || adr_o !== 32'h1000 + 32'(k * 4) || dat_o !== 32'(k)) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL wrap[%0d]: valid=%b adr=%h dat=%h, want 1 %h %h",
                   k, valid_o, adr_o, dat_o, 32'h1000 + 32'(k * 4), k);
      end
    end
    idle();
    checks++;
    if (empty_o !== 1'b1 || count_o !== 5'd0) begin
      errors++;
      $display("FAIL wrap_end: empty=%b count=%0d, want 1 0", empty_o, count_o);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 32'h500 + 32'(i), 32'h0, 32'h0, 4'h0, 1'b0);
      tick();
    end
    checks++;
    if (count_o !== 5'd5) begin
      errors++;
      $display("FAIL flush_pre: count=%0d, want 5", count_o);
    end
    set_in(1'b1, 1'b1, 1'b1, 32'h600, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    checks++;
    if (count_o !== 5'd0 || empty_o !== 1'b1 || valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d empty=%b valid=%b ovf=%b, want 0 1 0 1",
               count_o, empty_o, valid_o, overflow_o);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h300, 32'h33, 32'h0, 4'h0, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    checks++;
    if (valid_o !== 1'b1 || adr_o !== 32'h300 || dat_o !== 32'h33) begin
      errors++;
      $display("FAIL flush_after: valid=%b adr=%h dat=%h, want 1 300 33", valid_o, adr_o, dat_o);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 32'h700 + 32'(i), 32'hFF, 32'h9, 4'h7, 1'b1);
      tick();
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    // Still before the next rising edge: reset must act without a clock.
    checks++;
    if (valid_o !== 1'b0 || adr_o !== 32'h0 || dat_o !== 32'h0 || atomic_o !== 1'b0
        || count_o !== 5'd0 || empty_o !== 1'b1 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b adr=%h dat=%h count=%0d empty=%b ovf=%b, want 0 0 0 0 1 0",
               valid_o, adr_o, dat_o, count_o, empty_o, overflow_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h400, 32'h44, 32'h0, 4'h2, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    checks++;
    if (valid_o !== 1'b1 || adr_o !== 32'h400 || count_o !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_pop: valid=%b adr=%h count=%0d, want 1 400 0",
               valid_o, adr_o, count_o);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_drain();
    test_empty_push_pop();
    test_wrap();
    test_flush();
    test_async_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pu_or1k_store_buffer.md
PU_OR1K_STORE_BUFFER -- requirements
Module: pu_or1k_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH_WIDTH, default 4, entry count = 2**DEPTH_WIDTH (16).
REQ-002 SHALL have parameter OPTION_OPERAND_WIDTH, default 32, width of pc/address/data fields.
REQ-003 SHALL have ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pc_i  input  OPTION_OPERAND_WIDTH  PC of the store.
- adr_i  input  OPTION_OPERAND_WIDTH  store address.
- dat_i  input  OPTION_OPERAND_WIDTH  store data.
- bsel_i  input  OPTION_OPERAND_WIDTH/8  byte selects.
- atomic_i  input  1  store-conditional flag.
- write_i  input  1  push request.
- read_i  input  1  pop request.
- flush_i  input  1  discard all entries.
- pc_o, adr_o, dat_o, bsel_o, atomic_o  output  same widths as inputs  popped entry.
- valid_o  output  1  one-cycle pulse, popped entry on outputs.
- full_o  output  1  no free entry.
- empty_o  output  1  no stored entry.
- count_o  output  DEPTH_WIDTH+1  stored entry count.
- overflow_o  output  1  sticky: push attempted while full.

Function
REQ-004 SHALL store entries in an array of 2**DEPTH_WIDTH words of {pc, adr, dat, bsel, atomic}, one write port and one registered read port.
REQ-005 SHALL keep write and read pointers of DEPTH_WIDTH+1 bits; index = low DEPTH_WIDTH bits; wrap naturally modulo 2**(DEPTH_WIDTH+1).
REQ-006 SHALL drive empty_o = (wptr == rptr), full_o = (index bits equal AND MSBs differ), count_o = wptr - rptr (modulo arithmetic), all combinational from registered pointers.
REQ-007 Push accepted when write_i=1, full_o=0, flush_i=0: entry written at wptr index, wptr increments.
REQ-008 Pop accepted when read_i=1, empty_o=0, flush_i=0: rptr increments; entry at old rptr index on outputs next cycle with valid_o=1 for exactly that cycle.
REQ-009 Output fields SHALL hold last popped value until next accepted pop; valid_o=0 in any cycle not following an accepted pop.
REQ-010 full_o, empty_o evaluated on pre-edge state: full with write_i+read_i -> pop accepted, push rejected; empty with both -> push accepted, pop rejected (no write-to-read bypass).
REQ-011 Push and pop same cycle, neither boundary: both accepted, count_o unchanged.
REQ-012 Rejected push (full) SHALL not modify array or pointers; sets overflow_o=1, held until reset.
REQ-013 Rejected pop (empty) SHALL not modify state; valid_o=0 next cycle.
REQ-014 flush_i=1 SHALL set wptr=rptr=0 at next edge, override same-cycle write_i/read_i, force valid_o=0 next cycle; array contents not cleared; overflow_o unaffected.
REQ-015 Pop latency exactly 1 cycle; no combinational path from read_i/write_i to any output except via registered state.

Reset
REQ-016 rst_n=0 SHALL immediately set wptr=rptr=0, valid_o=0, overflow_o=0, pc_o/adr_o/dat_o/bsel_o/atomic_o=0; hence empty_o=1, full_o=0, count_o=0.
REQ-017 Reset mid-operation SHALL discard all entries; first accepted push after rst_n deassertion is at index 0.
REQ-018 Array contents need no reset.

Verification
REQ-019 Reset then push adr 0x100/dat 0xA5A5A5A5/bsel 0xF, pop next cycle -> cycle after pop: valid_o=1, adr_o=0x100, dat_o=0xA5A5A5A5, empty_o=1, count_o=0.
REQ-020 16 pushes adr 0x0..0x3C, 17th push 0x40 -> full_o=1 after 16th, count_o=16, overflow_o=1; 16 pops return 0x0..0x3C in order, 0x40 never output.
REQ-021 Full buffer, write_i+read_i same cycle -> pop of oldest entry, push rejected, count_o=15, overflow_o=1.
REQ-022 Empty buffer, write_i+read_i with adr 0x200 -> no valid_o next cycle, count_o=1; next pop returns 0x200.
REQ-023 Pointer wrap: 40 alternating push/pop pairs with adr incrementing by 4 -> every pop returns matching adr, empty_o=1 at end.
REQ-024 5 entries, flush_i with write_i+read_i -> next cycle count_o=0, empty_o=1, valid_o=0; rst_n pulsed mid-stream -> outputs zero immediately, asynchronously.
